// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the register-file writeback entry type.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Result producers (ALU, load unit), register-file write port and decode-stage forwarding query.
interface writeback_arbiter_if;
  import cpu_pkg::*;

  // Handshake: a producer holds *_valid with dest/data stable until the edge where
  // *_valid && *_ready are both high; that edge transfers exactly one result.
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0]     alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0]     mem_data;
  logic                  regWR;
  logic [REG_ADDR_W-1:0] destRegister;
  logic [DATA_W-1:0]     writeData;
  logic [NUM_REGS-1:0]   pending;
  logic [REG_ADDR_W-1:0] fwd_reg;
  logic                  fwd_hit;
  logic [DATA_W-1:0]     fwd_data;

  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, fwd_reg,
    output alu_ready, mem_ready, regWR, destRegister, writeData, pending, fwd_hit, fwd_data
  );

  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, fwd_reg,
    input  alu_ready, mem_ready, regWR, destRegister, writeData, pending, fwd_hit, fwd_data
  );

endinterface

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular buffer of writeback entries; storage is exposed
// so the owner can scan it for pending writes and forwarding.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       push_n_i,
  input  wb_entry_t        push_e0_i,
  input  wb_entry_t        push_e1_i,
  input  logic             pop_i,
  output wb_entry_t        entries_o [DEPTH],
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  // e0 is always the older of two same-edge pushes
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_n_i != 2'd0) mem_q[wr_ptr_q] <= push_e0_i;
      if (push_n_i == 2'd2) mem_q[wr_ptr_q + PTR_W'(1)] <= push_e1_i;
      wr_ptr_q <= wr_ptr_q + PTR_W'(push_n_i);
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_q + CNT_W'(push_n_i) - CNT_W'(pop_i);
    end
  end

  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into one ordered register-file write stream and
// provides a pending-write scoreboard plus a forwarding lookup for decode.
module writeback_arbiter
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  writeback_arbiter_if.slave wb,
  output logic [CNT_W-1:0]   count_o
);

  wb_entry_t             entries [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count, free;
  logic                  mem_rdy, alu_rdy, mem_acc, alu_acc, pop;
  logic [1:0]            push_n;
  wb_entry_t             mem_e, alu_e, push_e0, head;
  logic                  regwr_q, regwr_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NUM_REGS-1:0]   pending;
  logic                  fwd_hit;
  logic [DATA_W-1:0]     fwd_data;
  logic [PTR_W-1:0]      idx;

  // Readiness looks only at the pre-edge count; the load wins the last free slot.
  assign free    = CNT_W'(DEPTH) - count;
  assign mem_rdy = !rst && (free != '0);
  assign alu_rdy = !rst && ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !wb.mem_valid));
  assign mem_acc = wb.mem_valid && mem_rdy;
  assign alu_acc = wb.alu_valid && alu_rdy;
  assign push_n  = {1'b0, mem_acc} + {1'b0, alu_acc};
  assign mem_e   = '{dest: wb.mem_dest, data: wb.mem_data};
  assign alu_e   = '{dest: wb.alu_dest, data: wb.alu_data};
  assign push_e0 = mem_acc ? mem_e : alu_e;
  assign pop     = (count != '0);
  assign head    = entries[rd_ptr];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_n_i  (push_n),
    .push_e0_i (push_e0),
    .push_e1_i (alu_e),
    .pop_i     (pop),
    .entries_o (entries),
    .rd_ptr_o  (rd_ptr),
    .count_o   (count)
  );

  always_comb begin
    regwr_d = pop;
    dest_d  = dest_q;
    data_d  = data_q;
    if (pop) begin
      dest_d = head.dest;
      data_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwr_q <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
    end else begin
      regwr_q <= regwr_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  // Scan oldest to youngest so the youngest matching entry overrides the output stage.
  always_comb begin
    pending  = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (regwr_q) begin
      pending[dest_q] = 1'b1;
      if (dest_q == wb.fwd_reg) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        pending[entries[idx].dest] = 1'b1;
        if (entries[idx].dest == wb.fwd_reg) begin
          fwd_hit  = 1'b1;
          fwd_data = entries[idx].data;
        end
      end
    end
  end

  assign wb.mem_ready    = mem_rdy;
  assign wb.alu_ready    = alu_rdy;
  assign wb.regWR        = regwr_q;
  assign wb.destRegister = dest_q;
  assign wb.writeData    = data_q;
  assign wb.pending      = pending;
  assign wb.fwd_hit      = fwd_hit;
  assign wb.fwd_data     = fwd_data;
  assign count_o         = count;

endmodule
